elbeth_fetch_stage: RTL and testbench

Instruction fetch stage and IF/ID pipeline register of the ELBETH core; the producing end of elbeth_decoder's input interface.
- Owns the PC and issues word requests to instruction memory over a req/ack handshake.
- Splits each returned instruction into the field bundle elbeth_decoder consumes: opcode, inst_0..inst_4.
- Handles pipeline stall, flush, branch redirect and exception redirect.

---
 rtl/elbeth_fetch_stage_pkg.sv | 30 +++
 rtl/elbeth_ifid_reg.sv | 68 ++++++
 rtl/elbeth_fetch_stage.sv | 212 +++++++++++++++++++++
 tb/tb_elbeth_fetch_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/elbeth_fetch_stage_pkg.sv
// Shared definitions for the ELBETH fetch stage.
// Holds the instruction field bit ranges, the bubble instruction, the reset PC
// default and the fetch FSM state encoding.
package elbeth_fetch_stage_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] NopInst        = 32'h0000_0013;
    localparam logic [31:0] ResetPcDefault = 32'h0000_0000;

    localparam int unsigned OpcodeLsb = 0;
    localparam int unsigned OpcodeMsb = 6;
    localparam int unsigned Inst0Lsb  = 7;
    localparam int unsigned Inst0Msb  = 11;
    localparam int unsigned Inst1Lsb  = 12;
    localparam int unsigned Inst1Msb  = 14;
    localparam int unsigned Inst2Lsb  = 15;
    localparam int unsigned Inst2Msb  = 19;
    localparam int unsigned Inst3Lsb  = 20;
    localparam int unsigned Inst3Msb  = 24;
    localparam int unsigned Inst4Lsb  = 25;
    localparam int unsigned Inst4Msb  = 31;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StHold = 2'd2,
        StKill = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/elbeth_ifid_reg.sv
// IF/ID pipeline register of the ELBETH core.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   bubble            load NOP fields with valid=0 (wins over load)
//   load              load load_inst/load_pc/load_fault with valid=1
//   load_inst/pc      instruction word and its PC
//   load_fault        fetch fault; the word is replaced by NOP_INST
//   id_*              field split of the held instruction plus pc/valid/fault
// With neither bubble nor load asserted the register holds its contents.
module elbeth_ifid_reg
    import elbeth_fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INST = NopInst
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bubble,
    input  logic        load,
    input  logic [31:0] load_inst,
    input  logic [31:0] load_pc,
    input  logic        load_fault,
    output logic [6:0]  id_opcode,
    output logic [4:0]  id_inst_0,
    output logic [2:0]  id_inst_1,
    output logic [4:0]  id_inst_2,
    output logic [4:0]  id_inst_3,
    output logic [6:0]  id_inst_4,
    output logic [31:0] id_pc,
    output logic        id_valid,
    output logic        id_fetch_fault
);

    logic [31:0] inst_q;
    logic [31:0] pc_q;
    logic        valid_q;
    logic        fault_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_q  <= NOP_INST;
            pc_q    <= 32'h0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else if (bubble) begin
            inst_q  <= NOP_INST;
            pc_q    <= 32'h0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else if (load) begin
            // A faulting fetch carries no usable word downstream.
            inst_q  <= load_fault ? NOP_INST : load_inst;
            pc_q    <= load_pc;
            valid_q <= 1'b1;
            fault_q <= load_fault;
        end
    end

    assign id_opcode      = inst_q[OpcodeMsb:OpcodeLsb];
    assign id_inst_0      = inst_q[Inst0Msb:Inst0Lsb];
    assign id_inst_1      = inst_q[Inst1Msb:Inst1Lsb];
    assign id_inst_2      = inst_q[Inst2Msb:Inst2Lsb];
    assign id_inst_3      = inst_q[Inst3Msb:Inst3Lsb];
    assign id_inst_4      = inst_q[Inst4Msb:Inst4Lsb];
    assign id_pc          = pc_q;
    assign id_valid       = valid_q;
    assign id_fetch_fault = fault_q;

endmodule

// File: rtl/elbeth_fetch_stage.sv
// ELBETH instruction fetch stage: owns the PC, fetches words over a req/ack
// handshake and feeds the IF/ID register consumed by elbeth_decoder.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   imem_addr/req             word-aligned fetch request (stable until ack)
//   imem_ack/rdata/err        response strobe, instruction word, bus fault
//   if_stall, if_flush        hold IF/ID, replace IF/ID with a bubble
//   branch_taken/target       execute redirect
//   exc_taken/exc_pc          trap redirect, wins over branch
//   id_*                      IF/ID contents (fields, pc, valid, fault)
// Optional feature macro ELBETH_FETCH_MISALIGN_EN: when defined, a misaligned
// redirect target raises a fetch fault and parks the FSM in IDLE until the next
// redirect; when undefined the target's low two bits are cleared.
module elbeth_fetch_stage
    import elbeth_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = ResetPcDefault,
    parameter logic [31:0] NOP_INST = NopInst
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    input  logic        if_stall,
    input  logic        if_flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        exc_taken,
    input  logic [31:0] exc_pc,
    output logic [6:0]  id_opcode,
    output logic [4:0]  id_inst_0,
    output logic [2:0]  id_inst_1,
    output logic [4:0]  id_inst_2,
    output logic [4:0]  id_inst_3,
    output logic [6:0]  id_inst_4,
    output logic [31:0] id_pc,
    output logic        id_valid,
    output logic        id_fetch_fault
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  kill_addr_q, kill_addr_d;   // address of the request being discarded
    logic [31:0]  hold_data_q, hold_data_d;
    logic [31:0]  hold_pc_q, hold_pc_d;
    logic         hold_err_q, hold_err_d;
    logic         park_q, park_d;             // IDLE entered on a misaligned target

    logic         redirect;
    logic [31:0]  target_raw;
    logic [31:0]  target;
    logic         misalign;

    logic         ifid_bubble;
    logic         ifid_load;
    logic [31:0]  ld_inst;
    logic [31:0]  ld_pc;
    logic         ld_fault;

    assign redirect   = exc_taken | branch_taken;
    assign target_raw = exc_taken ? exc_pc : branch_target;

`ifdef ELBETH_FETCH_MISALIGN_EN
    assign target   = target_raw;
    assign misalign = |target_raw[1:0];
`else
    assign target   = target_raw & ~32'h3;
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            pc_q        <= RESET_PC;
            kill_addr_q <= RESET_PC;
            hold_data_q <= NOP_INST;
            hold_pc_q   <= 32'h0;
            hold_err_q  <= 1'b0;
            park_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            kill_addr_q <= kill_addr_d;
            hold_data_q <= hold_data_d;
            hold_pc_q   <= hold_pc_d;
            hold_err_q  <= hold_err_d;
            park_q      <= park_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        kill_addr_d = kill_addr_q;
        hold_data_d = hold_data_q;
        hold_pc_d   = hold_pc_q;
        hold_err_d  = hold_err_q;
        park_d      = park_q;
        ifid_bubble = 1'b0;
        ifid_load   = 1'b0;
        ld_inst     = imem_rdata;
        ld_pc       = pc_q;
        ld_fault    = imem_err;

        if (redirect) begin
            pc_d = target;
            if (misalign) begin
                ifid_load = 1'b1;
                ld_inst   = NOP_INST;
                ld_pc     = target;
                ld_fault  = 1'b1;
                park_d    = 1'b1;
            end else begin
                ifid_bubble = 1'b1;
                park_d      = 1'b0;
            end
            unique case (state_q)
                StReq: begin
                    if (imem_ack) begin
                        state_d = misalign ? StIdle : StReq;
                    end else begin
                        // Outstanding request must complete before the new PC goes out.
                        state_d     = StKill;
                        kill_addr_d = pc_q;
                    end
                end
                StKill: begin
                    if (imem_ack) state_d = misalign ? StIdle : StReq;
                end
                default: state_d = misalign ? StIdle : StReq;
            endcase
        end else if (if_flush) begin
            ifid_bubble = 1'b1;
            unique case (state_q)
                StHold: begin
                    // Buffered word is dropped; refetch it.
                    pc_d    = hold_pc_q;
                    state_d = StReq;
                end
                StKill: begin
                    if (imem_ack) state_d = park_q ? StIdle : StReq;
                end
                StIdle: begin
                    if (!park_q) state_d = StReq;
                end
                default: ;  // Any response this cycle is dropped and pc is kept.
            endcase
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!park_q) state_d = StReq;
                end
                StReq: begin
                    if (imem_ack) begin
                        pc_d = pc_q + 32'd4;
                        if (if_stall) begin
                            hold_data_d = imem_rdata;
                            hold_err_d  = imem_err;
                            hold_pc_d   = pc_q;
                            state_d     = StHold;
                        end else begin
                            ifid_load = 1'b1;
                        end
                    end else if (!if_stall) begin
                        ifid_bubble = 1'b1;
                    end
                end
                StHold: begin
                    if (!if_stall) begin
                        ifid_load = 1'b1;
                        ld_inst   = hold_data_q;
                        ld_pc     = hold_pc_q;
                        ld_fault  = hold_err_q;
                        state_d   = StReq;
                    end
                end
                StKill: begin
                    if (imem_ack) state_d = park_q ? StIdle : StReq;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign imem_req  = (state_q == StReq) || (state_q == StKill);
    assign imem_addr = (state_q == StKill) ? kill_addr_q : pc_q;

    elbeth_ifid_reg #(
        .NOP_INST (NOP_INST)
    ) u_ifid (
        .clk            (clk),
        .rst            (rst),
        .bubble         (ifid_bubble),
        .load           (ifid_load),
        .load_inst      (ld_inst),
        .load_pc        (ld_pc),
        .load_fault     (ld_fault),
        .id_opcode      (id_opcode),
        .id_inst_0      (id_inst_0),
        .id_inst_1      (id_inst_1),
        .id_inst_2      (id_inst_2),
        .id_inst_3      (id_inst_3),
        .id_inst_4      (id_inst_4),
        .id_pc          (id_pc),
        .id_valid       (id_valid),
        .id_fetch_fault (id_fetch_fault)
    );

endmodule

// File: tb/tb_elbeth_fetch_stage.sv
// Directed bench for elbeth_fetch_stage.
module tb_elbeth_fetch_stage;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        imem_err;
    logic        if_stall;
    logic        if_flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        exc_taken;
    logic [31:0] exc_pc;
    logic [6:0]  id_opcode;
    logic [4:0]  id_inst_0;
    logic [2:0]  id_inst_1;
    logic [4:0]  id_inst_2;
    logic [4:0]  id_inst_3;
    logic [6:0]  id_inst_4;
    logic [31:0] id_pc;
    logic        id_valid;
    logic        id_fetch_fault;

    int vectors    = 0;
    int miscompares = 0;

    elbeth_fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_req       (imem_req),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .imem_err       (imem_err),
        .if_stall       (if_stall),
        .if_flush       (if_flush),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .exc_taken      (exc_taken),
        .exc_pc         (exc_pc),
        .id_opcode      (id_opcode),
        .id_inst_0      (id_inst_0),
        .id_inst_1      (id_inst_1),
        .id_inst_2      (id_inst_2),
        .id_inst_3      (id_inst_3),
        .id_inst_4      (id_inst_4),
        .id_pc          (id_pc),
        .id_valid       (id_valid),
        .id_fetch_fault (id_fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, " req"},    32'(imem_req),       32'h0);
        chk({tag, " addr"},   imem_addr,           32'h0);
        chk({tag, " opcode"}, 32'(id_opcode),      32'h13);
        chk({tag, " inst0"},  32'(id_inst_0),      32'h0);
        chk({tag, " inst4"},  32'(id_inst_4),      32'h0);
        chk({tag, " pc"},     id_pc,               32'h0);
        chk({tag, " valid"},  32'(id_valid),       32'h0);
        chk({tag, " fault"},  32'(id_fetch_fault), 32'h0);
    endtask

    initial begin
        rst           = 1'b1;
        imem_ack      = 1'b0;
        imem_rdata    = 32'h0;
        imem_err      = 1'b0;
        if_stall      = 1'b0;
        if_flush      = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        exc_taken     = 1'b0;
        exc_pc        = 32'h0;

        #2;
        chk_reset_values("reset");
        step();
        step();
        rst        = 1'b0;        // IDLE this cycle
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0093;

        // 1: back-to-back fetch
        step();
        chk("t1 req0", 32'(imem_req), 32'h1);
        chk("t1 addr0", imem_addr, 32'h0);
        chk("t1 valid0", 32'(id_valid), 32'h0);
        step();
        chk("t1 addr4", imem_addr, 32'h4);
        chk("t1 opcode", 32'(id_opcode), 32'h13);
        chk("t1 inst0", 32'(id_inst_0), 32'h1);
        chk("t1 valid", 32'(id_valid), 32'h1);
        chk("t1 idpc0", id_pc, 32'h0);
        step();
        chk("t1 addr8", imem_addr, 32'h8);
        chk("t1 idpc4", id_pc, 32'h4);

        // 2: stall for 3 cycles, ack only in the first; word at pc 8 is buffered
        if_stall   = 1'b1;
        imem_rdata = 32'h0020_8113;   // addi x2, x1, 2
        step();
        imem_ack = 1'b0;
        chk("t2 req c2", 32'(imem_req), 32'h0);
        chk("t2 frozen c2", id_pc, 32'h4);
        step();
        chk("t2 req c3", 32'(imem_req), 32'h0);
        chk("t2 frozen c3", id_pc, 32'h4);
        chk("t2 frozen inst0", 32'(id_inst_0), 32'h1);
        step();
        if_stall = 1'b0;
        step();
        chk("t2 buf pc", id_pc, 32'h8);
        chk("t2 buf inst0", 32'(id_inst_0), 32'h2);
        chk("t2 buf inst2", 32'(id_inst_2), 32'h1);
        chk("t2 buf inst3", 32'(id_inst_3), 32'h2);
        chk("t2 buf valid", 32'(id_valid), 32'h1);
        chk("t2 next addr", imem_addr, 32'hC);
        chk("t2 req back", 32'(imem_req), 32'h1);

        // 3: branch while request to 0xC is pending without ack
        branch_taken  = 1'b1;
        branch_target = 32'h100;
        step();
        branch_taken = 1'b0;
        chk("t3 kill addr", imem_addr, 32'hC);
        chk("t3 kill req", 32'(imem_req), 32'h1);
        chk("t3 bubble valid", 32'(id_valid), 32'h0);
        chk("t3 bubble opcode", 32'(id_opcode), 32'h13);
        step();
        chk("t3 kill hold", imem_addr, 32'hC);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0093;
        step();
        chk("t3 new addr", imem_addr, 32'h100);
        chk("t3 discarded", 32'(id_valid), 32'h0);
        step();
        chk("t3 idpc", id_pc, 32'h100);
        chk("t3 valid", 32'(id_valid), 32'h1);
        chk("t3 addr104", imem_addr, 32'h104);

        // 4: exception and branch together, ack in the same cycle
        exc_taken     = 1'b1;
        exc_pc        = 32'h200;
        branch_taken  = 1'b1;
        branch_target = 32'h100;
        step();
        exc_taken    = 1'b0;
        branch_taken = 1'b0;
        chk("t4 exc addr", imem_addr, 32'h200);
        chk("t4 bubble", 32'(id_valid), 32'h0);
        step();
        chk("t4 idpc", id_pc, 32'h200);
        chk("t4 addr204", imem_addr, 32'h204);

        // 5: bus fault at 0x40; misaligned target is cleared in the default build
        branch_taken  = 1'b1;
        branch_target = 32'h43;
        step();
        branch_taken = 1'b0;
        chk("t5 addr40", imem_addr, 32'h40);
        imem_err = 1'b1;
        step();
        imem_err = 1'b0;
        chk("t5 fault", 32'(id_fetch_fault), 32'h1);
        chk("t5 idpc", id_pc, 32'h40);
        chk("t5 nop opcode", 32'(id_opcode), 32'h13);
        chk("t5 nop inst0", 32'(id_inst_0), 32'h0);
        chk("t5 valid", 32'(id_valid), 32'h1);
        chk("t5 addr44", imem_addr, 32'h44);

        // 6: PC wrap
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        step();
        branch_taken = 1'b0;
        chk("t6 addr top", imem_addr, 32'hFFFF_FFFC);
        step();
        chk("t6 wrap addr", imem_addr, 32'h0);
        chk("t6 idpc top", id_pc, 32'hFFFF_FFFC);
        chk("t6 fault clr", 32'(id_fetch_fault), 32'h0);

        // Flush with ack: response dropped, pc 0 refetched
        if_flush = 1'b1;
        step();
        if_flush = 1'b0;
        chk("flush addr", imem_addr, 32'h0);
        chk("flush valid", 32'(id_valid), 32'h0);
        step();
        chk("flush refetch pc", id_pc, 32'h0);
        chk("flush refetch valid", 32'(id_valid), 32'h1);
        chk("flush addr4", imem_addr, 32'h4);

        // Reset asserted while in KILL
        imem_ack      = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h300;
        step();
        branch_taken = 1'b0;
        chk("kill addr", imem_addr, 32'h4);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_values("midkill");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
